// File: rtl/cpu_trace_checker_if.sv
// Trace-checker bus: char/freq in, format_type/error_code/line_cnt out.
// master drives the trace stream, slave is the checker.
interface cpu_trace_checker_if;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [15:0] line_cnt;

  modport master (
    output char, freq,
    input  format_type, error_code, line_cnt
  );

  modport slave (
    input  char, freq,
    output format_type, error_code, line_cnt
  );
endinterface

// File: rtl/cpu_trace_checker.sv
// CPU trace line checker: parses reg/mem write lines, flags value errors.
// Ports: clk, reset (sync, active-high), bus (slave: char/freq -> results).
module cpu_trace_checker #(
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 4,
  parameter logic [31:0] PC_MIN      = 32'h0000_3000,
  parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_MAX    = 32'h0000_2fff,
  parameter int          REG_MAX     = 31
) (
  input logic                 clk,
  input logic                 reset,
  cpu_trace_checker_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_REG, S_ADDR,
    S_SP2, S_LT, S_SP3, S_DATA, S_HASH, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [13:0] tim, tim_n;
  logic [13:0] rg, rg_n;
  logic [31:0] pc, pc_n;
  logic [31:0] addr, addr_n;
  logic [31:0] data, data_n;
  logic [1:0]  typ, typ_n;
  logic [15:0] lines;

  logic [7:0] c;
  logic       is_dec, is_hex;
  logic [3:0] hv;

  assign c      = bus.char;
  assign is_dec = (c >= "0") && (c <= "9");
  assign is_hex = is_dec || ((c >= "a") && (c <= "f"));
  // 'a'..'f' have low nibbles 1..6
  assign hv     = is_dec ? c[3:0] : c[3:0] + 4'd9;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      tim   <= '0;
      rg    <= '0;
      pc    <= '0;
      addr  <= '0;
      data  <= '0;
      typ   <= '0;
      lines <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tim   <= tim_n;
      rg    <= rg_n;
      pc    <= pc_n;
      addr  <= addr_n;
      data  <= data_n;
      typ   <= typ_n;
      if (state_n == S_DONE && state != S_DONE
          && lines != 16'hffff)
        lines <= lines + 16'd1;
    end
  end

  always_comb begin
    logic fail;
    logic clr;
    state_n = state;
    cnt_n   = cnt;
    tim_n   = tim;
    rg_n    = rg;
    pc_n    = pc;
    addr_n  = addr;
    data_n  = data;
    typ_n   = typ;
    fail    = 1'b0;
    clr     = 1'b0;
    // '^' restarts from every state
    if (c == "^") begin
      state_n = S_TIME;
      clr     = 1'b1;
    end else begin
      case (state)
        S_IDLE: ;
        S_TIME:
          if (is_dec && int'(cnt) < TIME_DIGITS) begin
            cnt_n = cnt + 4'd1;
            tim_n = tim * 14'd10 + {10'd0, c[3:0]};
          end else if (c == "@" && cnt != 0) begin
            state_n = S_PC;
            cnt_n   = '0;
          end else fail = 1'b1;
        S_PC:
          if (is_hex) begin
            pc_n  = (pc << 4) | {28'd0, hv};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = S_COLON;
              cnt_n   = '0;
            end
          end else fail = 1'b1;
        S_COLON:
          if (c == ":") state_n = S_SP1;
          else fail = 1'b1;
        S_SP1:
          if (c == " ") ;
          else if (c == "$") begin
            state_n = S_REG;
            typ_n   = 2'd1;
          end else if (c == "*") begin
            state_n = S_ADDR;
            typ_n   = 2'd2;
          end else fail = 1'b1;
        S_REG:
          if (is_dec && int'(cnt) < REG_DIGITS) begin
            cnt_n = cnt + 4'd1;
            rg_n  = rg * 14'd10 + {10'd0, c[3:0]};
          end else if (c == " " && cnt != 0) begin
            state_n = S_SP2;
            cnt_n   = '0;
          end else if (c == "<" && cnt != 0) begin
            state_n = S_LT;
            cnt_n   = '0;
          end else fail = 1'b1;
        S_ADDR:
          if (is_hex) begin
            addr_n = (addr << 4) | {28'd0, hv};
            cnt_n  = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = S_SP2;
              cnt_n   = '0;
            end
          end else fail = 1'b1;
        S_SP2:
          if (c == " ") ;
          else if (c == "<") state_n = S_LT;
          else fail = 1'b1;
        S_LT:
          if (c == "=") state_n = S_SP3;
          else fail = 1'b1;
        S_SP3:
          if (c == " ") ;
          else if (is_hex) begin
            state_n = S_DATA;
            data_n  = {28'd0, hv};
            cnt_n   = 4'd1;
          end else fail = 1'b1;
        S_DATA:
          if (is_hex) begin
            data_n = (data << 4) | {28'd0, hv};
            cnt_n  = cnt + 4'd1;
            if (cnt == 4'd7) begin
              state_n = S_HASH;
              cnt_n   = '0;
            end
          end else fail = 1'b1;
        S_HASH:
          if (c == "#") state_n = S_DONE;
          else fail = 1'b1;
        S_DONE: fail = 1'b1;
        default: fail = 1'b1;
      endcase
    end
    if (fail) begin
      state_n = S_IDLE;
      clr     = 1'b1;
    end
    if (clr) begin
      cnt_n  = '0;
      tim_n  = '0;
      rg_n   = '0;
      pc_n   = '0;
      addr_n = '0;
      data_n = '0;
      typ_n  = '0;
    end
  end

  logic [15:0] half, mask;
  logic [3:0]  err;
  logic [1:0]  fmt;

  assign half = {1'b0, bus.freq[15:1]};
  assign mask = half - 16'd1;

  always_comb begin
    err[0] = (half != 0) && (({2'b0, tim} & mask) != 0);
    err[1] = (pc < PC_MIN) || (pc > PC_MAX) || (pc[1:0] != 0);
    err[2] = (typ == 2'd2)
             && ((addr > ADDR_MAX) || (addr[1:0] != 0));
    err[3] = (typ == 2'd1) && (int'(rg) > REG_MAX);
    fmt = '0;
    if (state == S_DONE) fmt = typ;
  end

  assign bus.format_type = fmt;
  assign bus.error_code  = (state == S_DONE) ? err : 4'd0;
  assign bus.line_cnt    = lines;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: drives trace lines,
// compares each DONE-cycle report against queued expectations.
module tb_cpu_trace_checker;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_trace_checker_if bus();

  cpu_trace_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  e;
    logic [15:0] n;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_exp    = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(logic [7:0] ch);
    @(posedge clk);
    #1 bus.char = ch;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic run(string s, logic [15:0] f,
                     logic [1:0] t, logic [3:0] e, bit ok);
    if (f != bus.freq) begin
      send("x");
      send("x");
      bus.freq = f;
    end
    if (ok) begin
      n_exp++;
      sb.push_back('{t, e, 16'(n_exp)});
    end
    send_str(s);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!reset && bus.format_type != 2'd0) begin
      if (sb.size() == 0) begin
        check("spurious", 32'(bus.format_type), 32'd0);
      end else begin
        x = sb.pop_front();
        check("type", 32'(bus.format_type), 32'(x.t));
        check("err", 32'(bus.error_code), 32'(x.e));
        check("cnt", 32'(bus.line_cnt), 32'(x.n));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    bus.char = 8'h00;
    bus.freq = 16'd4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_type", 32'(bus.format_type), 32'd0);
    check("rst_err", 32'(bus.error_code), 32'd0);
    check("rst_cnt", 32'(bus.line_cnt), 32'd0);

    run("^16@00003004: $28 <= ff00ff00#", 4, 1, 4'b0000, 1);
    run("^17@00002ffe: *00003000 <= 0000abcd#", 4, 2, 4'b0111, 1);
    run("^8@00003000: $32<=12345678#", 4, 1, 4'b1000, 1);
    run("^9999@00006ffc: *00002ffc <= deadbeef#", 4, 2, 4'b0001, 1);
    run("^12345@00003000: $1 <= 00000000#", 4, 0, 0, 0);
    run("^1@0000300A: $1 <= 00000000#", 4, 0, 0, 0);
    run("^1@00003^2@00003000: $1 <= 00000000#", 4, 1, 4'b0000, 1);
    run("^@00003000: $1 <= 00000000#", 4, 0, 0, 0);
    run("^7@00007000:   *00000001 <= 00000000#", 0, 2, 4'b0110, 1);
    run("^24@00003008: $31 <= 0badf00d#", 16, 1, 4'b0000, 1);
    run("^20@00003000: $0<=00000000#", 16, 1, 4'b0001, 1);
    run("^5@00003000: $3 <= 00000001#", 3, 1, 4'b0000, 1);
    run("^1@00003000: $0032 <= 11111111#", 3, 1, 4'b1000, 1);
    run("^1@00003000: $12345 <= 00000000#", 3, 0, 0, 0);
    repeat (3) send("x");
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("line_cnt", 32'(bus.line_cnt), 32'(n_exp));

    bus.freq = 16'd4;
    send_str("^16@00003004:");
    @(posedge clk);
    #1 reset = 1'b1;
    bus.char = " ";
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_type", 32'(bus.format_type), 32'd0);
    check("mid_rst_err", 32'(bus.error_code), 32'd0);
    check("mid_rst_cnt", 32'(bus.line_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    n_exp = 0;
    send_str("$28 <= ff00ff00#");
    repeat (3) send("x");
    check("after_rst_cnt", 32'(bus.line_cnt), 32'd0);

    run("^16@00003004: $28 <= ff00ff00#", 4, 1, 4'b0000, 1);
    repeat (3) send("x");
    check("final_empty", 32'(sb.size()), 32'd0);
    check("final_cnt", 32'(bus.line_cnt), 32'(n_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
